pixel_read_sched: RTL and testbench
===================================

Name: pixel_read_sched

Overview:
Read-side scheduler for the pixel output queue. Pops pixels from the queue read port into a 2-entry prefetch buffer and hands one pixel per video-timing request to the video output stage. Frame alignment comes from the queue's position field; on underrun or misalignment it substitutes black and resyncs at the next frame-start pixel. Sits between the pixel queue read side and the video sync generator, in the output clock domain.

Parameters:
FRAME_START_CODE, 3'd1, position code marking the first pixel of a frame; every other code is an ordinary pixel.
CNT_WIDTH, 16, width of the saturating status counters.

Ports:
clk  in  1  output clock
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  clock enable; all state except prefetch capture advances only when high
pixel_rd_en  out  1  queue pop; combinational
pixel_rd_empty  in  1  queue empty
pixel_rd_valid  in  1  queue data valid, 1 cycle after pop
y_in/u_in/v_in/osd_in  in  8 each  queue data
position_in  in  3  queue position code
pixel_req  in  1  sync generator wants an active pixel this cycle
frame_start  in  1  one-cycle pulse, at or before the first pixel_req of a frame
y_out/u_out/v_out/osd_out  out  8 each  registered pixel
pixel_out_valid  out  1  registered pixel_req
pixel_is_fill  out  1  current output is black fill, not queue data
synced  out  1  state==RUN
underrun_cnt  out  CNT_WIDTH  saturating underrun count
resync_cnt  out  CNT_WIDTH  saturating resync-entry count

Behaviour:
- Reset: state RESYNC, buffer and in-flight cleared, y_out=16, u_out=v_out=128, osd_out=0, pixel_out_valid=0, pixel_is_fill=0, counters 0.
- Prefetch:
  - buf_count (0..2) plus inflight (0..1) gives occupancy.
  - pixel_rd_en = clk_en && !pixel_rd_empty && (occupancy - consume_now) < 2.
  - inflight is set on pop and cleared on pixel_rd_valid.
  - Data is appended to the buffer whenever pixel_rd_valid is high, regardless of clk_en.
  - Sustains 1 pixel/cycle with pixel_req held high.
- head = oldest buffer entry. head_fs = head valid and its position == FRAME_START_CODE.
- Output latency: 1 cycle. Outputs register on the clk_en edge where pixel_req=1. pixel_out_valid = registered pixel_req.
- Fill pixel: y=16, u=128, v=128, osd=0, pixel_is_fill=1.
- RESYNC:
  - Each clk_en cycle, if head valid and !head_fs: discard head (consume, no output).
  - If head_fs: go to WAIT_FRAME.
  - Any pixel_req is answered with fill.
- WAIT_FRAME:
  - Hold head.
  - pixel_req without frame_start: answered with fill.
  - frame_start: go to RUN.
  - frame_start and pixel_req in the same cycle: output head, consume, go to RUN.
- RUN, on pixel_req:
  - Head valid, and not (head_fs and not first pixel): output head, consume.
  - Head empty (underrun): output fill, underrun_cnt++, go to RESYNC.
  - head_fs mid-frame (frame short): output fill, go to WAIT_FRAME, no consume.
- RUN, on frame_start:
  - head_fs: stay in RUN; that pixel is the frame's first.
  - Otherwise (frame long or leftover pixels): go to RESYNC.
- resync_cnt increments on every entry into RESYNC other than reset.
- Counters saturate at all-ones.
- Precedence in one cycle: the frame_start check is evaluated before pixel_req handling.
- rst mid-frame clears everything immediately. An in-flight pop completing after reset release is accepted into the buffer.
- Buffer never exceeds 2 entries. Overflow of the buffer is a design error and must be assertable in simulation.

Test Plan:
1. Queue preloaded with a 4x2 frame (first pos=1, rest 0, values 0..7); frame_start, then 8 consecutive pixel_req -> outputs 0..7 back-to-back, 1-cycle latency, pixel_is_fill=0, synced=1, at most 2 pops outstanding.
2. Queue holds 3 stray pixels (pos=0) then a frame (pos=1 head); reset -> 3 discarded, state WAIT_FRAME; pixel_req before frame_start -> fill (16,128,128,0).
3. Queue empties after 5 of 8 pixels -> pixel 6 is fill, underrun_cnt=1, resync_cnt=1, state RESYNC; next frame realigns.
4. Frame of 6 pixels, 8 requests -> requests 7 and 8 are fill, state WAIT_FRAME, next frame_start -> RUN with the correct first pixel.
5. clk_en toggled 1/0 with pixel_req held -> one pixel per enabled cycle, none lost or duplicated.
6. frame_start and pixel_req coincident in WAIT_FRAME -> first pixel output the same cycle; counter saturation forced at 16'hFFFF stays 16'hFFFF.

Source files
------------

// File: rtl/pixel_read_sched_if.sv
// Signal bundle joining the pixel queue read port and the video sync generator to pixel_read_sched.
interface pixel_read_sched_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 clk_en;
  logic                 pixel_rd_en;
  logic                 pixel_rd_empty;
  logic                 pixel_rd_valid;
  logic [7:0]           y_in;
  logic [7:0]           u_in;
  logic [7:0]           v_in;
  logic [7:0]           osd_in;
  logic [2:0]           position_in;
  logic                 pixel_req;
  logic                 frame_start;
  logic [7:0]           y_out;
  logic [7:0]           u_out;
  logic [7:0]           v_out;
  logic [7:0]           osd_out;
  logic                 pixel_out_valid;
  logic                 pixel_is_fill;
  logic                 synced;
  logic [CNT_WIDTH-1:0] underrun_cnt;
  logic [CNT_WIDTH-1:0] resync_cnt;
  logic [1:0]           state_dbg;

  // Queue side: a pop is taken on every clk edge where pixel_rd_en is high; the popped word arrives
  // with pixel_rd_valid exactly one cycle later. Video side: every enabled pixel_req is answered by
  // pixel_out_valid one cycle later, with no back-pressure.
  modport master (
    output clk_en, pixel_rd_empty, pixel_rd_valid, y_in, u_in, v_in, osd_in, position_in,
           pixel_req, frame_start,
    input  pixel_rd_en, y_out, u_out, v_out, osd_out, pixel_out_valid, pixel_is_fill, synced,
           underrun_cnt, resync_cnt, state_dbg
  );

  modport slave (
    input  clk_en, pixel_rd_empty, pixel_rd_valid, y_in, u_in, v_in, osd_in, position_in,
           pixel_req, frame_start,
    output pixel_rd_en, y_out, u_out, v_out, osd_out, pixel_out_valid, pixel_is_fill, synced,
           underrun_cnt, resync_cnt, state_dbg
  );
endinterface

// File: rtl/pixel_read_sched.sv
// Prefetches queue pixels into a 2-entry buffer and serves one per video request; substitutes black
// and realigns on the frame-start position code whenever frame alignment is lost.
module pixel_read_sched #(
  parameter logic [2:0] FRAME_START_CODE = 3'd1,
  parameter int         CNT_WIDTH        = 16
) (
  input logic               clk,
  input logic               rst,
  pixel_read_sched_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic [7:0] osd;
    logic [2:0] pos;
  } pix_t;

  localparam logic [31:0]          FILL_PIX = {8'd16, 8'd128, 8'd128, 8'd0};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 first_q, first_d;
  pix_t                 buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]           buf_cnt_q, buf_cnt_d, cnt_mid;
  logic                 inflight_q, inflight_d;
  logic [31:0]          out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 fill_q, fill_d;
  logic [CNT_WIDTH-1:0] underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] resync_q, resync_d;

  pix_t       in_pix, head;
  logic       head_valid, head_fs;
  logic       consume, emit_head, underrun_evt, resync_evt;
  logic       rd_en, buf_overflow;
  logic [2:0] occ_after;

  assign in_pix     = {bus.y_in, bus.u_in, bus.v_in, bus.osd_in, bus.position_in};
  assign head       = buf0_q;
  assign head_valid = (buf_cnt_q != 2'd0);
  assign head_fs    = head_valid && (head.pos == FRAME_START_CODE);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESYNC;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // FSM: next state. A frame_start in RUN is judged before any pixel_req in the same cycle.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    if (bus.clk_en) begin
      case (state_q)
        ST_RESYNC: if (head_fs) state_d = ST_WAIT;
        ST_WAIT: begin
          if (bus.frame_start) begin
            state_d = ST_RUN;
            first_d = !bus.pixel_req;
          end
        end
        ST_RUN: begin
          if (bus.frame_start && !head_fs) begin
            state_d = ST_RESYNC;
          end else begin
            if (bus.frame_start) first_d = 1'b1;
            if (emit_head)          first_d = 1'b0;
            else if (underrun_evt)  state_d = ST_RESYNC;
            else if (bus.pixel_req) state_d = ST_WAIT;
          end
        end
        default: state_d = ST_RESYNC;
      endcase
    end
  end

  // FSM: outputs (head consumption and pixel source for this cycle)
  always_comb begin
    consume      = 1'b0;
    emit_head    = 1'b0;
    underrun_evt = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        ST_RESYNC: consume = head_valid && !head_fs;
        ST_WAIT:   emit_head = bus.frame_start && bus.pixel_req && head_valid;
        ST_RUN: begin
          if (bus.pixel_req && (!bus.frame_start || head_fs)) begin
            emit_head    = head_valid && (!head_fs || first_q || bus.frame_start);
            underrun_evt = !head_valid;
          end
        end
        default: ;
      endcase
      if (emit_head) consume = 1'b1;
    end
  end

  // Pop whenever the buffer plus the outstanding pop would still leave room after this cycle's consume.
  assign occ_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, consume};
  assign rd_en     = bus.clk_en && !bus.pixel_rd_empty && (occ_after < 3'd2);

  always_comb begin
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    cnt_mid      = buf_cnt_q;
    buf_overflow = 1'b0;
    if (consume) begin
      buf0_d  = buf1_q;
      cnt_mid = buf_cnt_q - 2'd1;
    end
    buf_cnt_d = cnt_mid;
    if (bus.pixel_rd_valid) begin
      if (cnt_mid == 2'd0) buf0_d = in_pix;
      else                 buf1_d = in_pix;
      buf_overflow = (cnt_mid == 2'd2);
      if (!buf_overflow) buf_cnt_d = cnt_mid + 2'd1;
    end
  end

  assign resync_evt = bus.clk_en && (state_q != ST_RESYNC) && (state_d == ST_RESYNC);

  always_comb begin
    inflight_d  = rd_en ? 1'b1 : (bus.pixel_rd_valid ? 1'b0 : inflight_q);
    out_valid_d = bus.clk_en && bus.pixel_req;
    out_d       = out_q;
    fill_d      = fill_q;
    if (out_valid_d) begin
      if (emit_head) begin
        out_d  = {head.y, head.u, head.v, head.osd};
        fill_d = 1'b0;
      end else begin
        out_d  = FILL_PIX;
        fill_d = 1'b1;
      end
    end
    underrun_d = underrun_q;
    if (underrun_evt && (underrun_q != '1)) underrun_d = underrun_q + CNT_ONE;
    resync_d = resync_q;
    if (resync_evt && (resync_q != '1)) resync_d = resync_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q      <= '0;
      buf1_q      <= '0;
      buf_cnt_q   <= 2'd0;
      inflight_q  <= 1'b0;
      out_q       <= FILL_PIX;
      out_valid_q <= 1'b0;
      fill_q      <= 1'b0;
      underrun_q  <= '0;
      resync_q    <= '0;
    end else begin
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf_cnt_q   <= buf_cnt_d;
      inflight_q  <= inflight_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      fill_q      <= fill_d;
      underrun_q  <= underrun_d;
      resync_q    <= resync_d;
    end
  end

  // A third buffered pixel means the pop throttle is broken.
  assert property (@(posedge clk) disable iff (rst) !buf_overflow);

  assign bus.pixel_rd_en     = rd_en;
  assign bus.y_out           = out_q[31:24];
  assign bus.u_out           = out_q[23:16];
  assign bus.v_out           = out_q[15:8];
  assign bus.osd_out         = out_q[7:0];
  assign bus.pixel_out_valid = out_valid_q;
  assign bus.pixel_is_fill   = fill_q;
  assign bus.synced          = (state_q == ST_RUN);
  assign bus.underrun_cnt    = underrun_q;
  assign bus.resync_cnt      = resync_q;
  assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_pixel_read_sched.sv
// Directed bench for pixel_read_sched: queue model, request sequences and an expected-output scoreboard.
module tb_pixel_read_sched;
  localparam int         W  = 33;
  localparam logic [2:0] FS = 3'd1;
  localparam logic [W-1:0] EXP_FILL = {1'b1, 8'd16, 8'd128, 8'd128, 8'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_read_sched_if #(.CNT_WIDTH(16)) bus ();
  pixel_read_sched_if #(.CNT_WIDTH(2))  sat_bus ();

  pixel_read_sched #(.FRAME_START_CODE(3'd1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // Narrow-counter twin fed identical stimulus so saturation is reachable in a short run.
  pixel_read_sched #(.FRAME_START_CODE(3'd1), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(sat_bus)
  );

  assign sat_bus.clk_en         = bus.clk_en;
  assign sat_bus.pixel_rd_empty = bus.pixel_rd_empty;
  assign sat_bus.pixel_rd_valid = bus.pixel_rd_valid;
  assign sat_bus.y_in           = bus.y_in;
  assign sat_bus.u_in           = bus.u_in;
  assign sat_bus.v_in           = bus.v_in;
  assign sat_bus.osd_in         = bus.osd_in;
  assign sat_bus.position_in    = bus.position_in;
  assign sat_bus.pixel_req      = bus.pixel_req;
  assign sat_bus.frame_start    = bus.frame_start;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [34:0]  model_q[$];
  logic [34:0]  held;
  bit           pop_pending;

  function automatic logic [34:0] mk(input logic [2:0] pos, input logic [7:0] v);
    return {v, v + 8'h40, v + 8'h80, v ^ 8'h55, pos};
  endfunction

  function automatic logic [W-1:0] exp_pix(input logic [7:0] v);
    return {1'b0, v, v + 8'h40, v + 8'h80, v ^ 8'h55};
  endfunction

  // Queue model: pop sampled just before the edge, data presented one cycle later.
  initial begin
    bus.pixel_rd_valid = 1'b0;
    bus.pixel_rd_empty = 1'b1;
    {bus.y_in, bus.u_in, bus.v_in, bus.osd_in, bus.position_in} = '0;
    pop_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        {bus.y_in, bus.u_in, bus.v_in, bus.osd_in, bus.position_in} = held;
        bus.pixel_rd_valid = 1'b1;
      end else begin
        bus.pixel_rd_valid = 1'b0;
      end
      bus.pixel_rd_empty = (model_q.size() == 0);
      #4;
      if (bus.pixel_rd_en && model_q.size() != 0) begin
        held = model_q.pop_front();
        pop_pending = 1'b1;
      end else begin
        pop_pending = 1'b0;
      end
    end
  end

  logic [W-1:0] got, want;
  always @(negedge clk) begin
    if (bus.pixel_out_valid === 1'b1) begin
      got = {bus.pixel_is_fill, bus.y_out, bus.u_out, bus.v_out, bus.osd_out};
      if (exp_q.size() != 0) want = exp_q.pop_front();
      else want = 'x;
      tests++;
      assert (got === want) else begin
        fails++;
        $error("FAIL pixel_out observed=%0h expected=%0h", got, want);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit req, input bit fs, input bit fill, input logic [7:0] v);
    @(negedge clk);
    bus.clk_en      = en;
    bus.pixel_req   = req;
    bus.frame_start = fs;
    if (en && req) exp_q.push_back(fill ? EXP_FILL : exp_pix(v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic push_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) model_q.push_back(mk((i == 0) ? FS : 3'd0, base + 8'(i)));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_y"}, 32'(bus.y_out), 32'd16);
    check({tag, "_u"}, 32'(bus.u_out), 32'd128);
    check({tag, "_v"}, 32'(bus.v_out), 32'd128);
    check({tag, "_osd"}, 32'(bus.osd_out), 32'd0);
    check({tag, "_valid"}, 32'(bus.pixel_out_valid), 32'd0);
    check({tag, "_fill"}, 32'(bus.pixel_is_fill), 32'd0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
    check({tag, "_underrun"}, 32'(bus.underrun_cnt), 32'd0);
    check({tag, "_resync"}, 32'(bus.resync_cnt), 32'd0);
  endtask

  initial begin
    bus.clk_en      = 1'b0;
    bus.pixel_req   = 1'b0;
    bus.frame_start = 1'b0;

    // Reset state, then a preloaded 8-pixel frame streamed back-to-back.
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset_synced", 32'(bus.synced), 32'd0);
    push_frame(8, 8'd0);
    rst = 1'b0;
    idle(8);
    check("t1_wait_state", 32'(bus.state_dbg), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
    idle(1);
    check("t1_synced", 32'(bus.synced), 32'd1);
    check("t1_underrun", 32'(bus.underrun_cnt), 32'd0);
    idle(1);

    // Mid-frame reset, then stray pixels ahead of a 5-pixel frame.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    model_q.delete();
    for (int i = 0; i < 3; i++) model_q.push_back(mk(3'd0, 8'hA0 + 8'(i)));
    push_frame(5, 8'h10);
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check("t2_wait_state", 32'(bus.state_dbg), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, (i >= 5), 8'h10 + 8'(i));
    idle(1);
    check("t3_underrun", 32'(bus.underrun_cnt), 32'd1);
    check("t3_resync", 32'(bus.resync_cnt), 32'd1);
    check("t3_state", 32'(bus.state_dbg), 32'd0);

    // Short frame (6 pixels for 8 requests) followed by the next frame already queued.
    push_frame(6, 8'h20);
    push_frame(4, 8'h30);
    idle(8);
    check("t4_wait_state", 32'(bus.state_dbg), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, (i >= 6), 8'h20 + 8'(i));
    idle(1);
    check("t4_state", 32'(bus.state_dbg), 32'd1);
    check("t4_resync", 32'(bus.resync_cnt), 32'd1);

    // frame_start coincident with the first request while waiting.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h30);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
    idle(1);
    check("t6_synced", 32'(bus.synced), 32'd1);

    // clk_en toggling with pixel_req held high.
    push_frame(6, 8'h40);
    idle(6);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) step((i % 2 == 0), 1'b1, 1'b0, 1'b0, 8'h40 + 8'(i / 2));
    idle(2);
    check("t5_synced", 32'(bus.synced), 32'd1);
    check("t5_underrun", 32'(bus.underrun_cnt), 32'd1);

    // Repeated underruns drive the narrow counters into saturation.
    for (int k = 1; k <= 4; k++) begin
      push_frame(1, 8'h50 + 8'(k));
      idle(6);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h50 + 8'(k));
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
      idle(1);
      check("sat_underrun_wide", 32'(bus.underrun_cnt), 32'(1 + k));
      check("sat_resync_wide", 32'(bus.resync_cnt), 32'(1 + k));
      check("sat_underrun_narrow", 32'(sat_bus.underrun_cnt), 32'((1 + k > 3) ? 3 : 1 + k));
      check("sat_resync_narrow", 32'(sat_bus.resync_cnt), 32'((1 + k > 3) ? 3 : 1 + k));
    end
    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Reset with non-zero counters clears everything.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    #1;
    check_reset("final_rst");
    check("final_rst_narrow", 32'(sat_bus.underrun_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
